// File: rtl/sram_ctrl_param.sv
// sram_ctrl_param: multi-beat controller between the MEM stage and an
// asynchronous SRAM. One DATA_W word is moved as DATA_W/SRAM_DQ_W narrow
// beats, least-significant beat first. Each beat is held WAIT_CYCLES+1 cycles.
// Optional build macro SRAM_CTRL_BYTE_EN adds byte enables (byteEn / SRAM_BE_N).
//
// state | meaning
// IDLE  | ready for a request, SRAM bus released, SRAM_ADDR = 0
// WRITE | driving beats of the latched write word, SRAM_WE_N low
// READ  | sampling SRAM_DQ beats into the assembly register
module sram_ctrl_param #(
  parameter int DATA_W      = 32,
  parameter int SRAM_DQ_W   = 16,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   writeEn,
  input  logic                   readEn,
  input  logic [31:0]            address,
  input  logic [DATA_W-1:0]      WriteData,
`ifdef SRAM_CTRL_BYTE_EN
  input  logic [DATA_W/8-1:0]    byteEn,
  output logic [SRAM_DQ_W/8-1:0] SRAM_BE_N,
`endif
  output logic [DATA_W-1:0]      ReadData,
  output logic                   ready,
  output logic                   done,
  output logic [SRAM_AW-1:0]     SRAM_ADDR,
  output logic                   SRAM_WE_N,
  inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ
);

  localparam int BEATS = DATA_W / SRAM_DQ_W;
  localparam int BB    = (BEATS > 1) ? $clog2(BEATS) : 0;
  localparam int BW    = (BB > 0) ? BB : 1;
  localparam int AL    = SRAM_AW - BB;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [3:0]    WAIT_LAST = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t                 state_q, state_d;
  logic [BW-1:0]          beat_q;
  logic [3:0]             wait_q;
  logic [AL-1:0]          addr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [DATA_W-1:0]      asm_q, asm_d;
  logic [SRAM_AW-1:0]     addr_full;
  logic                   beat_end, last_cycle;
  logic                   dq_oe;
  logic [SRAM_DQ_W-1:0]   dq_out;
`ifdef SRAM_CTRL_BYTE_EN
  localparam int LN = SRAM_DQ_W / 8;
  logic [DATA_W/8-1:0]    be_q;
`endif

  assign beat_end   = (wait_q == WAIT_LAST);
  assign last_cycle = beat_end && (beat_q == BEAT_LAST);

  // Beat index occupies the SRAM address LSBs; upper word-address bits wrap.
  if (BB == 0) begin : g_addr_single
    assign addr_full = addr_q;
  end else begin : g_addr_multi
    assign addr_full = {addr_q, beat_q[BB-1:0]};
  end

  if (AL < 32) begin : g_addr_drop
    logic unused_addr;
    assign unused_addr = ^address[31:AL];
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state: writeEn wins over readEn; busy states leave after the last beat
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (writeEn)     state_d = WRITE;
        else if (readEn) state_d = READ;
      end
      WRITE, READ: begin
        if (last_cycle) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch and beat/wait sequencing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_q  <= '0;
      wait_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef SRAM_CTRL_BYTE_EN
      be_q    <= '0;
`endif
    end else if (state_q == IDLE) begin
      beat_q <= '0;
      wait_q <= '0;
      if (writeEn || readEn) begin
        addr_q  <= address[AL-1:0];
        wdata_q <= WriteData;
`ifdef SRAM_CTRL_BYTE_EN
        be_q    <= byteEn;
`endif
      end
    end else if (beat_end) begin
      wait_q <= '0;
      if (!last_cycle) beat_q <= beat_q + 1'b1;
    end else begin
      wait_q <= wait_q + 4'd1;
    end
  end

  // Merge the beat being sampled so the final beat reaches ReadData on the same edge
  always_comb begin
    asm_d = asm_q;
    if (state_q == READ && beat_end)
      asm_d[int'(beat_q)*SRAM_DQ_W +: SRAM_DQ_W] = SRAM_DQ;
  end

  // Read assembly, registered read word and completion pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_q    <= '0;
      ReadData <= '0;
      done     <= 1'b0;
    end else begin
      asm_q <= asm_d;
      done  <= (state_q != IDLE) && last_cycle;
      if (state_q == READ && last_cycle) ReadData <= asm_d;
    end
  end

  // SRAM pins and handshake derived from state
  always_comb begin
    ready     = (state_q == IDLE);
    SRAM_WE_N = 1'b1;
    SRAM_ADDR = '0;
    dq_oe     = 1'b0;
    dq_out    = wdata_q[int'(beat_q)*SRAM_DQ_W +: SRAM_DQ_W];
`ifdef SRAM_CTRL_BYTE_EN
    SRAM_BE_N = '1;
`endif
    if (state_q != IDLE) SRAM_ADDR = addr_full;
    if (state_q == WRITE) begin
      SRAM_WE_N = 1'b0;
      dq_oe     = 1'b1;
`ifdef SRAM_CTRL_BYTE_EN
      SRAM_BE_N = ~be_q[int'(beat_q)*LN +: LN];
`endif
    end
`ifdef SRAM_CTRL_BYTE_EN
    if (state_q == READ) SRAM_BE_N = '0;
`endif
  end

  assign SRAM_DQ = dq_oe ? dq_out : {SRAM_DQ_W{1'bz}};

endmodule

// File: tb/tb_sram_ctrl_param.sv
// Bench for sram_ctrl_param: default instance (32/16, one wait cycle) and a
// 64-bit zero-wait instance, each attached to a small SRAM model.
`timescale 1ns/1ps
module tb_sram_ctrl_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // instance 0: defaults
  logic        we0 = 1'b0, re0 = 1'b0;
  logic [31:0] a0 = '0, wd0 = '0, rd0;
  logic        rdy0, dn0, wen0;
  logic [17:0] sa0;
  wire  [15:0] dq0;
  logic [15:0] mem0 [256];
  logic [1:0]  lane0;
  logic [31:0] rd_exp0 = '0;
  logic [63:0] q0 [$];

  // instance 1: 64-bit word, no wait cycles
  logic        we1 = 1'b0, re1 = 1'b0;
  logic [31:0] a1 = '0;
  logic [63:0] wd1 = '0, rd1;
  logic        rdy1, dn1, wen1;
  logic [17:0] sa1;
  wire  [15:0] dq1;
  logic [15:0] mem1 [256];
  logic [1:0]  lane1;
  logic [63:0] rd_exp1 = '0;
  logic [63:0] q1 [$];

`ifdef SRAM_CTRL_BYTE_EN
  logic [3:0] be0 = 4'hF;
  logic [1:0] ben0;
  logic [7:0] be1 = 8'hFF;
  logic [1:0] ben1;
  assign lane0 = ben0;
  assign lane1 = ben1;
`else
  assign lane0 = 2'b00;
  assign lane1 = 2'b00;
`endif

  sram_ctrl_param u0 (
    .clk(clk), .rst(rst), .writeEn(we0), .readEn(re0), .address(a0),
    .WriteData(wd0),
`ifdef SRAM_CTRL_BYTE_EN
    .byteEn(be0), .SRAM_BE_N(ben0),
`endif
    .ReadData(rd0), .ready(rdy0), .done(dn0), .SRAM_ADDR(sa0),
    .SRAM_WE_N(wen0), .SRAM_DQ(dq0)
  );

  sram_ctrl_param #(.DATA_W(64), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .writeEn(we1), .readEn(re1), .address(a1),
    .WriteData(wd1),
`ifdef SRAM_CTRL_BYTE_EN
    .byteEn(be1), .SRAM_BE_N(ben1),
`endif
    .ReadData(rd1), .ready(rdy1), .done(dn1), .SRAM_ADDR(sa1),
    .SRAM_WE_N(wen1), .SRAM_DQ(dq1)
  );

  // SRAM models: drive the bus while the controller is busy reading
  assign dq0 = (!rdy0 && wen0) ? mem0[sa0[7:0]] : 16'hzzzz;
  assign dq1 = (!rdy1 && wen1) ? mem1[sa1[7:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (rst && !wen0)
      for (int l = 0; l < 2; l++)
        if (!lane0[l]) mem0[sa0[7:0]][l*8 +: 8] <= dq0[l*8 +: 8];
    if (rst && !wen1)
      for (int l = 0; l < 2; l++)
        if (!lane1[l]) mem1[sa1[7:0]][l*8 +: 8] <= dq1[l*8 +: 8];
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Scoreboard: each done pops the ReadData expected for that access
  always @(negedge clk) begin
    if (dn0) begin
      if (q0.size() == 0) check("done0_unexpected", 64'(dn0), 64'd0);
      else check("rdata0_at_done", 64'(rd0), q0.pop_front());
    end
    if (dn1) begin
      if (q1.size() == 0) check("done1_unexpected", 64'(dn1), 64'd0);
      else check("rdata1_at_done", rd1, q1.pop_front());
    end
  end

  // Called at a negedge in IDLE; returns at the negedge of the done cycle.
  task automatic access0(input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rexp, input bit poke);
    int b;
    we0 = w; re0 = r; a0 = a; wd0 = d;
    if (w) q0.push_back(64'(rd_exp0));
    else begin
      q0.push_back(64'(rexp));
      rd_exp0 = rexp;
    end
    @(negedge clk);
    we0 = poke; re0 = poke;
    for (int k = 0; k < 4; k++) begin
      b = k / 2;
      if (k == 3) begin we0 = 1'b0; re0 = 1'b0; end
      check("busy0", 64'(rdy0), 64'd0);
      check("addr0", 64'(sa0), 64'({a[16:0], b[0]}));
      check("we_n0", 64'(wen0), 64'(!w));
      if (w) check("dq0", 64'(dq0), 64'(d[b*16 +: 16]));
`ifdef SRAM_CTRL_BYTE_EN
      check("be_n0", 64'(ben0), w ? 64'(~be0[b*2 +: 2]) : 64'd0);
`endif
      @(negedge clk);
    end
    check("ready0", 64'(rdy0), 64'd1);
    check("done0", 64'(dn0), 64'd1);
  endtask

  task automatic access1(input logic w, input logic r, input logic [31:0] a,
                         input logic [63:0] d, input logic [63:0] rexp);
    we1 = w; re1 = r; a1 = a; wd1 = d;
    if (w) q1.push_back(rd_exp1);
    else begin
      q1.push_back(rexp);
      rd_exp1 = rexp;
    end
    @(negedge clk);
    we1 = 1'b0; re1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("busy1", 64'(rdy1), 64'd0);
      check("addr1", 64'(sa1), 64'({a[15:0], k[1:0]}));
      check("we_n1", 64'(wen1), 64'(!w));
      if (w) check("dq1", 64'(dq1), 64'(d[k*16 +: 16]));
      @(negedge clk);
    end
    check("ready1", 64'(rdy1), 64'd1);
    check("done1", 64'(dn1), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready0", 64'(rdy0), 64'd1);
    check("rst_we_n0", 64'(wen0), 64'd1);
    check("rst_done0", 64'(dn0), 64'd0);
    check("rst_rdata0", 64'(rd0), 64'd0);
    check("rst_addr0", 64'(sa0), 64'd0);
    check("rst_dq_oe0", 64'(u0.dq_oe), 64'd0);
    check("rst_ready1", 64'(rdy1), 64'd1);
    rst = 1'b1;
    @(negedge clk);

    // write, read back, write leaves ReadData alone
    access0(1'b1, 1'b0, 32'h5, 32'hDEADBEEF, 32'h0, 1'b0);
    @(negedge clk);
    check("done0_one_cycle", 64'(dn0), 64'd0);
    access0(1'b0, 1'b1, 32'h5, 32'h0, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    access0(1'b1, 1'b0, 32'h6, 32'h12345678, 32'h0, 1'b0);
    @(negedge clk);
    check("rdata0_hold", 64'(rd0), 64'hDEADBEEF);

    // both enables: write wins; requests while busy are dropped
    access0(1'b1, 1'b1, 32'h8, 32'hA5A55A5A, 32'h0, 1'b1);
    repeat (3) @(negedge clk);
    check("no_second_done0", 64'(dn0), 64'd0);
    access0(1'b0, 1'b1, 32'h8, 32'h0, 32'hA5A55A5A, 1'b0);
    @(negedge clk);
    // upper address bits wrap into the same SRAM row
    access0(1'b0, 1'b1, 32'h0002_0005, 32'h0, 32'hDEADBEEF, 1'b0);
    @(negedge clk);

`ifdef SRAM_CTRL_BYTE_EN
    be0 = 4'b0010;
    access0(1'b1, 1'b0, 32'h9, 32'h11223344, 32'h0, 1'b0);
    be0 = 4'hF;
    @(negedge clk);
`endif

    // 64-bit zero-wait instance with back-to-back accepts in the done cycle
    @(negedge clk);
    access1(1'b1, 1'b0, 32'h3, 64'h0123456789ABCDEF, 64'h0);
    access1(1'b0, 1'b1, 32'h3, 64'h0, 64'h0123456789ABCDEF);
    access1(1'b1, 1'b0, 32'h4, 64'hCAFEF00D12345678, 64'h0);
    access1(1'b0, 1'b1, 32'h4, 64'h0, 64'hCAFEF00D12345678);
    access1(1'b0, 1'b1, 32'h3, 64'h0, 64'h0123456789ABCDEF);
    @(negedge clk);

    // reset during beat 1 of a read aborts it
    re0 = 1'b1; a0 = 32'h5;
    @(negedge clk);
    re0 = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_read_busy0", 64'(rdy0), 64'd0);
    check("mid_read_beat1", 64'(sa0), 64'h0B);
    rst = 1'b0;
    #1;
    check("abort_ready0", 64'(rdy0), 64'd1);
    check("abort_we_n0", 64'(wen0), 64'd1);
    check("abort_addr0", 64'(sa0), 64'd0);
    check("abort_done0", 64'(dn0), 64'd0);
    check("abort_rdata0", 64'(rd0), 64'd0);
    check("abort_rdata1", rd1, 64'd0);
    rd_exp0 = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_done0", 64'(dn0), 64'd0);
    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
